lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_controller.sv | 171 +++++++++++++++++
 tb/tb_lsu_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// Load/store unit controller: accepts one RV32 load/store at a time, checks it
// for alignment, width code and address range, drives a word-organised data
// memory with byte-lane enables, and returns a sign/zero-extended load result
// with a one-cycle completion pulse.
module lsu_controller #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_byte_we,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [ADDRESS_WIDTH-1:0] r_mem_addr;
  logic [1:0]               r_off;
  logic [1:0]               r_size;      // funct3[1:0]: 0 byte, 1 half, 2 word
  logic                     r_unsigned;  // funct3[2]
  logic                     r_we;
  logic [31:0]              r_wdata;
  logic [31:0]              r_resp_rdata;
  logic                     r_resp_err;

  logic                     w_accept;
  logic                     w_funct3_ok;
  logic                     w_misaligned;
  logic                     w_out_of_range;
  logic                     w_err;
  logic [3:0]               w_lane_base;
  logic [31:0]              w_load_shifted;
  logic [31:0]              w_load_ext;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Classify the incoming request: legal width code, natural alignment, address range.
  always_comb begin
    w_funct3_ok = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_funct3_ok = 1'b1;
      3'b100, 3'b101:         w_funct3_ok = !req_we;  // unsigned forms exist only for loads
      default:                w_funct3_ok = 1'b0;
    endcase
    w_misaligned = 1'b0;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
      w_misaligned = 1'b1;
    end
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
      w_misaligned = 1'b1;
    end
    w_out_of_range = (req_addr >> ADDRESS_WIDTH) != 32'd0;
    w_err          = !w_funct3_ok || w_misaligned || w_out_of_range;
  end

  // Align the returned word to the addressed byte and extend to 32 bits.
  always_comb begin
    w_load_shifted = mem_rdata >> {r_off, 3'b000};
    case (r_size)
      2'd0:    w_load_ext = {{24{!r_unsigned && w_load_shifted[7]}}, w_load_shifted[7:0]};
      2'd1:    w_load_ext = {{16{!r_unsigned && w_load_shifted[15]}}, w_load_shifted[15:0]};
      default: w_load_ext = w_load_shifted;
    endcase
  end

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_byte_we  = 4'b0000;
    w_lane_base  = (r_size == 2'd0) ? 4'b0001 :
                   (r_size == 2'd1) ? 4'b0011 : 4'b1111;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = w_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Gated by rst_n so a reset landing on this edge suppresses the write.
        if (r_we && rst_n) begin
          mem_byte_we = w_lane_base << r_off;
        end
        w_state_next = r_we ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Request latching at accept and response capture on every entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_addr   <= '0;
      r_off        <= 2'b00;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_err) begin
          r_resp_err   <= 1'b1;
          r_resp_rdata <= 32'd0;
        end else begin
          r_mem_addr <= {req_addr[ADDRESS_WIDTH-1:2], 2'b00};
          r_off      <= req_addr[1:0];
          r_size     <= req_funct3[1:0];
          r_unsigned <= req_funct3[2];
          r_we       <= req_we;
          if (req_we) begin
            r_wdata <= req_wdata << {req_addr[1:0], 3'b000};
          end
        end
      end
      if ((r_state == S_ISSUE) && r_we) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= 32'd0;
      end
      if (r_state == S_WAIT) begin
        r_resp_err   <= 1'b0;
        r_resp_rdata <= w_load_ext;
      end
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_wdata;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed scenarios plus randomized
// load/store traffic checked against a byte-addressed reference memory.
module tb_lsu_controller;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_byte_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] dmem    [0:63];   // data memory seen by the DUT
  logic [7:0]  ref_mem [0:255];  // reference byte memory

  lsu_controller #(.ADDRESS_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_byte_we (mem_byte_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory with byte enables and a one-cycle registered read.
  always @(posedge clk) begin
    logic [31:0] nw;
    nw = dmem[mem_addr[7:2]];
    for (int b = 0; b < 4; b++) begin
      if (mem_byte_we[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
    end
    dmem[mem_addr[7:2]] <= nw;
    mem_rdata <= dmem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference classification of a request.
  function automatic void ref_eval(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   output logic err, output int sz);
    logic legal;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    sz    = 1 << f3[1:0];
    err   = !legal || ((addr % sz) != 0) || (addr > 32'd255);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int          sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v  = 32'd0;
    for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[int'(addr[7:0]) + k]) << (8 * k));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    int sz;
    sz = 1 << f3[1:0];
    for (int k = 0; k < sz; k++) ref_mem[int'(addr[7:0]) + k] = wdata[8*k +: 8];
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready !== 1'b1) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one request, follow it to its response and check everything observable.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rdata);
    logic        exp_err;
    int          sz;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          lat;
    int          be_pulses;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [31:0] addr_seen;
    logic        err_seen;

    ref_eval(we, f3, addr, exp_err, sz);
    exp_lat   = exp_err ? 1 : (we ? 2 : 3);
    exp_rdata = (exp_err || we) ? 32'd0 : ref_load(f3, addr);
    exp_be    = 4'b0000;
    if (!exp_err && we) begin
      for (int k = 0; k < sz; k++) exp_be[int'(addr[1:0]) + k] = 1'b1;
    end
    exp_wd = wdata << (8 * addr[1:0]);

    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;

    got_rdata = 32'd0;
    err_seen  = 1'b0;
    lat       = 0;
    be_pulses = 0;
    be_seen   = 4'b0000;
    wd_seen   = 32'd0;
    addr_seen = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 1) addr_seen = 32'(mem_addr);
      if (mem_byte_we != 4'b0000) begin
        be_pulses++;
        be_seen = mem_byte_we;
        wd_seen = mem_wdata;
      end
      if (resp_valid === 1'b1) begin
        lat       = c;
        got_rdata = resp_rdata;
        err_seen  = resp_err;
        break;
      end
      @(posedge clk); #1;
    end

    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(err_seen), 32'(exp_err));
    check("resp_rdata", got_rdata, exp_rdata);
    check("we_pulses", 32'(be_pulses), (!exp_err && we) ? 32'd1 : 32'd0);
    if (!exp_err) check("mem_addr", addr_seen, addr & 32'hFC);
    if (!exp_err && we) begin
      check("byte_we", 32'(be_seen), 32'(exp_be));
      check("mem_wdata", wd_seen, exp_wd);
    end

    // Cycle after RESP: pulse gone, ready again, response held.
    @(posedge clk); #1;
    check("resp_pulse_end", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    check("rdata_hold", resp_rdata, exp_rdata);
    check("err_hold", 32'(resp_err), 32'(exp_err));

    if (!exp_err && we) ref_store(f3, addr, wdata);
    $display("[TB] txn we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h",
             we, f3, addr, wdata, lat, err_seen, got_rdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    logic [31:0] dA;
    logic [31:0] dB;
    logic [7:0]  we_bits;
    logic [7:0]  rv_bits;
    logic [7:0]  rdy_bits;

    for (int i = 0; i < 64; i++) begin
      dmem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = dmem[i][8*b +: 8];
    end
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_byte_we", 32'(mem_byte_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // Store word then sub-word loads from it.
    run_req(1'b1, 3'b010, 32'd12, 32'hCAFEBABE, got);
    run_req(1'b0, 3'b000, 32'd15, 32'd0, got);
    check("lb15", got, 32'hFFFFFFCA);
    run_req(1'b0, 3'b100, 32'd15, 32'd0, got);
    check("lbu15", got, 32'h000000CA);
    run_req(1'b0, 3'b001, 32'd14, 32'd0, got);
    check("lh14", got, 32'hFFFFCAFE);
    run_req(1'b0, 3'b010, 32'd12, 32'd0, got);
    check("lw12", got, 32'hCAFEBABE);

    // Upper-half store and unsigned half load.
    run_req(1'b1, 3'b001, 32'd22, 32'h00001234, got);
    run_req(1'b0, 3'b101, 32'd22, 32'd0, got);
    check("lhu22", got, 32'h00001234);

    // Rejected requests.
    run_req(1'b0, 3'b010, 32'd13, 32'd0, got);
    run_req(1'b1, 3'b001, 32'd21, 32'h5555AAAA, got);
    run_req(1'b0, 3'b011, 32'd0, 32'd0, got);
    run_req(1'b1, 3'b010, 32'h100, 32'h12345678, got);
    run_req(1'b1, 3'b100, 32'd8, 32'h12345678, got);

    // Reset landing on the edge that ends ISSUE aborts the store.
    prior = {ref_mem[23], ref_mem[22], ref_mem[21], ref_mem[20]};
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd20;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("abort_we_issue", 32'(mem_byte_we), 32'd0);
    @(posedge clk); #1;
    check("abort_we_after", 32'(mem_byte_we), 32'd0);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    check("abort_err_clr", 32'(resp_err), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_mem_word", dmem[5], prior);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_no_resp2", 32'(resp_valid), 32'd0);
    run_req(1'b0, 3'b010, 32'd20, 32'd0, got);
    check("abort_lw20", got, prior);

    // req_valid held across two stores.
    dA = $urandom;
    dB = $urandom;
    wait_ready();
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd40;
    req_wdata  = dA;
    @(posedge clk); #1;
    req_funct3 = 3'b000;
    req_addr   = 32'd45;
    req_wdata  = dB;
    we_bits  = 8'd0;
    rv_bits  = 8'd0;
    rdy_bits = 8'd0;
    for (int c = 1; c <= 6; c++) begin
      we_bits[c]  = (mem_byte_we != 4'b0000);
      rv_bits[c]  = resp_valid;
      rdy_bits[c] = req_ready;
      if (c == 4) begin
        check("b2b_wdata", mem_wdata, dB << 8);
        check("b2b_addr", 32'(mem_addr), 32'd44);
      end
      if (c == 5) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_we_cycles", 32'(we_bits), 32'h12);
    check("b2b_resp_cycles", 32'(rv_bits), 32'h24);
    check("b2b_ready_cycles", 32'(rdy_bits), 32'h48);
    ref_store(3'b010, 32'd40, dA);
    ref_store(3'b000, 32'd45, dB);
    $display("[TB] txn back-to-back stores addr 40/45 -> we=0x%02h resp=0x%02h ready=0x%02h",
             we_bits, rv_bits, rdy_bits);

    // Randomized traffic.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      int          r;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h100 + $urandom_range(0, 3);
      else             a = $urandom_range(0, 255);
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, got);
    end

    // Final readback of every word.
    for (int a = 0; a < 256; a += 4) begin
      run_req(1'b0, 3'b010, 32'(a), 32'd0, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
